// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite bus bundle with initiator and target views
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  logic [ADDR_BIT_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_BIT_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]         wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_BIT_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slv_port (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_mst_bridge.sv
// rtl/axi4_lite_mst_bridge.sv - single-outstanding command/response to AXI4-Lite initiator
// Optional watchdog flag o_timeout is built when AXI4_LITE_MST_BRIDGE_TIMEOUT_EN is defined.
module axi4_lite_mst_bridge #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
  output logic                        o_timeout,
`endif
  axi4_lite_if.mst_port               if_m_axi4_lite
);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  if ((DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("axi4_lite_mst_bridge: unsupported DATA_BIT_WIDTH or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                    state_q, state_d;
  logic                      is_wr_q, is_wr_d;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: if (cmd_ready_q && i_cmd_valid) begin
        is_wr_d   = i_cmd_is_wr;
        addr_d    = i_cmd_addr;
        wdata_d   = i_cmd_wdata;
        wstrb_d   = i_cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = i_cmd_is_wr ? WR_REQ : RD_REQ;
      end
      // AW and W complete independently; leave only once both have handshaken.
      WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid_q & if_m_axi4_lite.awready);
        w_done_d  = w_done_q | (wvalid_q & if_m_axi4_lite.wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (bready_q && if_m_axi4_lite.bvalid) begin
        rdata_d = '0;
        resp_d  = if_m_axi4_lite.bresp;
        state_d = RSP;
      end
      RD_REQ: if (arvalid_q && if_m_axi4_lite.arready) state_d = RD_DATA;
      RD_DATA: if (rready_q && if_m_axi4_lite.rvalid) begin
        rdata_d = if_m_axi4_lite.rdata;
        resp_d  = if_m_axi4_lite.rresp;
        state_d = RSP;
      end
      RSP: if (rsp_valid_q && i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state's decode.
    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign o_cmd_ready           = cmd_ready_q;
  assign o_rsp_valid           = rsp_valid_q;
  assign o_rsp_is_wr           = is_wr_q;
  assign o_rsp_rdata           = rdata_q;
  assign o_rsp_resp            = resp_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  // Watchdog only flags a stuck slave; the transaction itself is never abandoned.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (state_d == state_q && (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA})) begin
      wd_cnt_d = (wd_cnt_q == CNT_W'(TIMEOUT_CYC)) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    if (wd_cnt_d == CNT_W'(TIMEOUT_CYC)) timeout_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
`endif
endmodule

// File: tb/tb_axi4_lite_mst_bridge.sv
// tb/tb_axi4_lite_mst_bridge.sv - randomized self-checking bench for axi4_lite_mst_bridge
module tb_axi4_lite_mst_bridge;
  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_is_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_is_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
  logic        timeout;
`endif

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) axi ();

  axi4_lite_mst_bridge #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_is_wr(cmd_is_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_is_wr(rsp_is_wr),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
    .o_timeout(timeout),
`endif
    .if_m_axi4_lite(axi)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] map_resp(input logic [31:0] a);
    return (a < 32'h100) ? 2'b00 : ((a < 32'h1000) ? 2'b10 : 2'b11);
  endfunction

  // Slave knobs: lat < 0 means random ready every cycle, dly < 0 means random 0..3.
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_dly = 0, r_dly = 0;
  bit b_hold = 0, r_hold = 0;
  int b_count = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] slv_mem [0:63];

  initial begin
    bit h_aw, h_w, h_b, h_ar, h_r, aw_got, w_got, ar_got, b_armed, r_armed;
    bit p_aw, p_w, p_ar;
    logic [31:0] n_awaddr, n_wdata, n_araddr, s_awaddr, s_wdata, s_araddr;
    logic [3:0] n_wstrb, s_wstrb;
    logic [35:0] hold_w;
    logic [31:0] hold_aw, hold_ar;
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    {aw_got, w_got, ar_got, b_armed, r_armed, p_aw, p_w, p_ar} = '0;
    {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
    for (int i = 0; i < 64; i++) slv_mem[i] = '0;
    {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
    axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
    forever begin
      @(negedge clk);
      h_aw = axi.awvalid && axi.awready; n_awaddr = axi.awaddr;
      h_w  = axi.wvalid && axi.wready;   n_wdata = axi.wdata; n_wstrb = axi.wstrb;
      h_b  = axi.bvalid && axi.bready;
      h_ar = axi.arvalid && axi.arready; n_araddr = axi.araddr;
      h_r  = axi.rvalid && axi.rready;
      if (!rst_n) begin
        {p_aw, p_w, p_ar} = '0;
      end else begin
        if (p_aw) chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, hold_aw});
        if (p_w)  chk("w_hold", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, hold_w});
        if (p_ar) chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, hold_ar});
        if (axi.awvalid) chk("awprot", axi.awprot, 0);
        if (axi.arvalid) chk("arprot", axi.arprot, 0);
        if (axi.bready || axi.rready) chk("rdy_excl", axi.bready & axi.rready, 0);
      end
      p_aw = axi.awvalid && !axi.awready; hold_aw = axi.awaddr;
      p_w  = axi.wvalid && !axi.wready;   hold_w = {axi.wstrb, axi.wdata};
      p_ar = axi.arvalid && !axi.arready; hold_ar = axi.araddr;
      if (axi.awvalid) aw_cyc++;
      if (axi.wvalid) w_cyc++;
      aw_wait = p_aw ? aw_wait + 1 : 0;
      w_wait  = p_w ? w_wait + 1 : 0;
      ar_wait = p_ar ? ar_wait + 1 : 0;
      @(posedge clk); #1;
      if (!rst_n) begin
        {aw_got, w_got, ar_got, b_armed, r_armed} = '0;
        {aw_wait, w_wait, ar_wait} = '0;
        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
        continue;
      end
      if (h_aw) begin aw_got = 1; s_awaddr = n_awaddr; end
      if (h_w) begin w_got = 1; s_wdata = n_wdata; s_wstrb = n_wstrb; end
      if (h_b) begin axi.bvalid = 0; b_count++; end
      if (h_ar) begin ar_got = 1; s_araddr = n_araddr; end
      if (h_r) axi.rvalid = 0;
      if (aw_got && w_got) begin
        axi.bresp = map_resp(s_awaddr);
        if (axi.bresp == 2'b00)
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) slv_mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
        {aw_got, w_got} = '0;
        b_armed = 1; b_wait = (b_dly < 0) ? int'($urandom_range(0, 3)) : b_dly;
      end
      if (b_armed && !b_hold) begin
        if (b_wait == 0) begin axi.bvalid = 1; b_armed = 0; end else b_wait--;
      end
      if (ar_got) begin
        axi.rresp = map_resp(s_araddr);
        axi.rdata = (axi.rresp == 2'b00) ? slv_mem[s_araddr[7:2]] : 32'h0;
        ar_got = 0; r_armed = 1; r_wait = (r_dly < 0) ? int'($urandom_range(0, 3)) : r_dly;
      end
      if (r_armed && !r_hold) begin
        if (r_wait == 0) begin axi.rvalid = 1; r_armed = 0; end else r_wait--;
      end
      axi.awready = (aw_lat < 0) ? 1'($urandom_range(0, 1)) : (axi.awvalid && aw_wait >= aw_lat);
      axi.wready  = (w_lat < 0)  ? 1'($urandom_range(0, 1)) : (axi.wvalid && w_wait >= w_lat);
      axi.arready = (ar_lat < 0) ? 1'($urandom_range(0, 1)) : (axi.arvalid && ar_wait >= ar_lat);
    end
  end

  // Reference model: expected response per command from the address map and byte strobes.
  logic [31:0] ref_mem [0:63];
  logic        exp_wr;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;

  task automatic start_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic [31:0] mask;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_is_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    b_count = 0; aw_cyc = 0; w_cyc = 0;
    exp_wr = wr; exp_resp = map_resp(a);
    if (wr) begin
      exp_rdata = '0;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (exp_resp == 2'b00) ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~mask) | (d & mask);
    end else begin
      exp_rdata = (exp_resp == 2'b00) ? ref_mem[a[7:2]] : 32'h0;
    end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic finish_cmd(input int hold, input bit chk_lat);
    int n = 1;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    if (chk_lat) chk("latency", n, 3);
    for (int i = 0; i < hold; i++) begin
      chk("hold_fields", {rsp_valid, cmd_ready, rsp_is_wr, rsp_resp, rsp_rdata},
          {1'b1, 1'b0, exp_wr, exp_resp, exp_rdata});
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    chk("rsp_is_wr", rsp_is_wr, exp_wr);
    chk("rsp_resp", rsp_resp, exp_resp);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {cmd_ready, rsp_valid, rsp_is_wr, rsp_resp, axi.awvalid, axi.wvalid,
                     axi.bready, axi.arvalid, axi.rready}, 0);
    chk("rst_rdata", rsp_rdata, 0);
`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif
    #1 rst_n = 1;
    chk("cmd_ready_at_release", cmd_ready, 0);
    @(posedge clk); #1;
    chk("cmd_ready_first_edge", cmd_ready, 1);

    // Zero-wait write
    start_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("aw_w_valid_cyc1", {axi.awvalid, axi.wvalid}, 2'b11);
    finish_cmd(0, 1);

    // awready delayed 3 cycles, wready immediate
    aw_lat = 3;
    start_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
    finish_cmd(0, 0);
    chk("aw_valid_cycles", aw_cyc, 4);
    chk("w_valid_cycles", w_cyc, 1);
    chk("b_count", b_count, 1);
    aw_lat = 0;

    start_cmd(0, 32'h10, 32'h0, 4'h0);
    finish_cmd(0, 1);
    start_cmd(0, 32'h200, 32'h0, 4'h0);
    finish_cmd(0, 0);

    // Response back-pressure for 5 cycles
    start_cmd(0, 32'h10, 32'h0, 4'h0);
    finish_cmd(5, 1);

`ifdef AXI4_LITE_MST_BRIDGE_TIMEOUT_EN
    b_hold = 1;
    start_cmd(1, 32'h20, 32'h12345678, 4'hF);
    n = 0;
    while (!axi.bready && n < 20) begin @(posedge clk); #1; n++; end
    chk("bready_reached", axi.bready, 1);
    chk("timeout_before", timeout, 0);
    n = 0;
    while (!timeout && n < 40) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", n, TO_CYC);
    chk("bready_during_timeout", axi.bready, 1);
    b_hold = 0;
    finish_cmd(0, 0);
    chk("timeout_sticky", timeout, 1);
`endif

    aw_lat = -1; w_lat = -1; ar_lat = -1; b_dly = -1; r_dly = -1;
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = 32'h300;
        1:       a = 32'h2000;
        default: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      start_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      finish_cmd(int'($urandom_range(0, 2)), 0);
    end

    // Reset in RD_DATA while rvalid is held off
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_dly = 0; r_dly = 0;
    r_hold = 1;
    start_cmd(0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!axi.rready && n < 20) begin @(posedge clk); #1; n++; end
    chk("rd_data_reached", axi.rready, 1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_outs", {cmd_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.bready,
                           axi.arvalid, axi.rready}, 0);
    r_hold = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1;
    start_cmd(0, 32'h10, 32'h0, 4'h0);
    finish_cmd(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
